// File: rtl/uart_config_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_config_sequencer_if
//   Byte-stream handshake between the UART FIFOs and the configuration
//   sequencer.
//   rx_data_i / rx_valid_i : received byte plus its one-cycle strobe
//                            (RX FIFO -> sequencer)
//   tx_data_o / tx_valid_o : response byte, held until accepted
//                            (sequencer -> TX FIFO)
//   tx_ready_i             : TX FIFO accepts the byte when high with tx_valid_o
//   Modports: slave = the sequencer, master = the FIFO side / bench.
// ---------------------------------------------------------------------------
interface uart_config_sequencer_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    input  tx_ready_i,
    output tx_data_o,
    output tx_valid_o
  );

  modport master (
    output rx_data_i,
    output rx_valid_i,
    output tx_ready_i,
    input  tx_data_o,
    input  tx_valid_o
  );
endinterface

// File: rtl/uart_config_sequencer.sv
// ---------------------------------------------------------------------------
// uart_config_sequencer
//   Runtime line-configuration controller for the UART. Watches the received
//   byte stream for SYN_NUMBER consecutive SYN characters, then accepts
//   configuration packets ({4'h0, id[1:0], option[1:0]}) and answers each with
//   ACK or NAK. A valid end packet commits the shadow frame format to config_o
//   once its ACK has been handed to the TX path.
//
//   Ports
//     clk_i             system clock
//     rst_n_i           asynchronous active-low reset
//     bus (slave)       rx byte strobe in, tx response byte out (handshaked)
//     config_o          active format {data_width, parity_mode, stop_bits}
//     config_active_o   configuration session open
//     int_config_req_o  one-cycle pulse, session opened
//     int_config_fail_o one-cycle pulse, session aborted (NAK or timeout)
//     int_config_done_o one-cycle pulse, new format committed
// ---------------------------------------------------------------------------
module uart_config_sequencer #(
  parameter logic [7:0] SYN_CHAR       = 8'h16,
  parameter logic [7:0] ACK_CHAR       = 8'h06,
  parameter logic [7:0] NAK_CHAR       = 8'h15,
  parameter int         SYN_NUMBER     = 3,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  uart_config_sequencer_if.slave        bus,
  output logic [5:0]                    config_o,
  output logic                          config_active_o,
  output logic                          int_config_req_o,
  output logic                          int_config_fail_o,
  output logic                          int_config_done_o
);

  localparam int SYN_W = $clog2(SYN_NUMBER + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [SYN_W-1:0] SYN_LAST = SYN_W'(SYN_NUMBER - 1);
  // The session is aborted on the idle cycle that brings the count to
  // TIMEOUT_CYCLES-1, so the decision is taken while it still reads one less.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);

  // 8 data bits, even parity, 1 stop bit
  localparam logic [5:0] CFG_DEFAULT = 6'b11_00_00;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CFG_WAIT = 2'b01,
    RESPOND  = 2'b10
  } state_t;

  // -------------------------------------------------------------------------
  // Packet helpers
  // -------------------------------------------------------------------------

  // A packet is valid when the upper nibble is clear and the option is legal
  // for its ID. Parity options 10/11 are both "disabled" and therefore legal.
  function automatic logic pkt_is_valid(input logic [7:0] pkt);
    logic ok;
    ok = 1'b0;
    if (pkt[7:4] != 4'h0) begin
      ok = 1'b0;
    end else begin
      case (pkt[3:2])
        2'b00:   ok = (pkt[1:0] == 2'b00);
        2'b01:   ok = 1'b1;
        2'b10:   ok = 1'b1;
        2'b11:   ok = (pkt[1] == 1'b0);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Replace the field selected by the packet ID with the packet option.
  function automatic logic [5:0] shadow_write(input logic [5:0] cur,
                                              input logic [3:0] pkt);
    logic [5:0] nxt;
    nxt = cur;
    case (pkt[3:2])
      2'b01:   nxt = {pkt[1:0], cur[3:0]};
      2'b10:   nxt = {cur[5:4], pkt[1:0], cur[1:0]};
      2'b11:   nxt = {cur[5:2], pkt[1:0]};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_r;
  logic [SYN_W-1:0] syn_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic [5:0]       config_r;
  logic [5:0]       shadow_r;
  logic             commit_pending_r;
  logic             fail_pending_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r;
  logic             active_r;
  logic             req_r;
  logic             fail_r;
  logic             done_r;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic       syn_hit_s;
  logic       syn_done_s;
  logic       pkt_ok_s;
  logic       pkt_end_s;
  logic       handshake_s;
  logic       timeout_s;
  logic [5:0] shadow_next_s;

  // Classify the incoming byte and the current handshake / timeout status.
  always_comb begin
    syn_hit_s     = 1'b0;
    syn_done_s    = 1'b0;
    pkt_ok_s      = 1'b0;
    pkt_end_s     = 1'b0;
    shadow_next_s = shadow_r;
    handshake_s   = tx_valid_r & bus.tx_ready_i;
    timeout_s     = (to_cnt_r == TO_LAST);

    if (bus.rx_valid_i && (bus.rx_data_i == SYN_CHAR)) begin
      syn_hit_s  = 1'b1;
      syn_done_s = (syn_cnt_r == SYN_LAST);
    end else begin
      syn_hit_s  = 1'b0;
      syn_done_s = 1'b0;
    end

    if (pkt_is_valid(bus.rx_data_i)) begin
      pkt_ok_s      = 1'b1;
      pkt_end_s     = (bus.rx_data_i[3:2] == 2'b00);
      shadow_next_s = shadow_write(shadow_r, bus.rx_data_i[3:0]);
    end else begin
      pkt_ok_s      = 1'b0;
      pkt_end_s     = 1'b0;
      shadow_next_s = shadow_r;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // -------------------------------------------------------------------------

  // Session control, response generation, shadow/commit and interrupt pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r          <= IDLE;
      syn_cnt_r        <= '0;
      to_cnt_r         <= '0;
      config_r         <= CFG_DEFAULT;
      shadow_r         <= CFG_DEFAULT;
      commit_pending_r <= 1'b0;
      fail_pending_r   <= 1'b0;
      tx_data_r        <= 8'h00;
      tx_valid_r       <= 1'b0;
      active_r         <= 1'b0;
      req_r            <= 1'b0;
      fail_r           <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      // Interrupts are single-cycle unless re-armed below.
      req_r  <= 1'b0;
      fail_r <= 1'b0;
      done_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (bus.rx_valid_i) begin
            if (syn_done_s) begin
              state_r   <= CFG_WAIT;
              syn_cnt_r <= '0;
              to_cnt_r  <= '0;
              shadow_r  <= config_r;
              req_r     <= 1'b1;
              active_r  <= 1'b1;
            end else if (syn_hit_s) begin
              syn_cnt_r <= syn_cnt_r + 1'b1;
            end else begin
              syn_cnt_r <= '0;
            end
          end
        end

        CFG_WAIT: begin
          if (bus.rx_valid_i) begin
            to_cnt_r   <= '0;
            tx_valid_r <= 1'b1;
            state_r    <= RESPOND;
            if (pkt_ok_s) begin
              tx_data_r <= ACK_CHAR;
              if (pkt_end_s) begin
                commit_pending_r <= 1'b1;
              end else begin
                shadow_r <= shadow_next_s;
              end
            end else begin
              tx_data_r      <= NAK_CHAR;
              fail_pending_r <= 1'b1;
            end
          end else if (timeout_s) begin
            // Silent abort: no response byte, active format untouched.
            to_cnt_r <= '0;
            fail_r   <= 1'b1;
            active_r <= 1'b0;
            shadow_r <= config_r;
            state_r  <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + 1'b1;
          end
        end

        RESPOND: begin
          // rx strobes are ignored here and the timeout counter holds.
          if (handshake_s) begin
            tx_valid_r       <= 1'b0;
            commit_pending_r <= 1'b0;
            fail_pending_r   <= 1'b0;
            if (commit_pending_r) begin
              // The end-packet ACK went out under the old format; switch now.
              config_r <= shadow_r;
              done_r   <= 1'b1;
              active_r <= 1'b0;
              state_r  <= IDLE;
            end else if (fail_pending_r) begin
              fail_r   <= 1'b1;
              shadow_r <= config_r;
              active_r <= 1'b0;
              state_r  <= IDLE;
            end else begin
              to_cnt_r <= '0;
              state_r  <= CFG_WAIT;
            end
          end
        end

        default: begin
          state_r          <= IDLE;
          syn_cnt_r        <= '0;
          to_cnt_r         <= '0;
          commit_pending_r <= 1'b0;
          fail_pending_r   <= 1'b0;
          tx_valid_r       <= 1'b0;
          active_r         <= 1'b0;
          shadow_r         <= config_r;
        end
      endcase
    end
  end

  assign bus.tx_data_o     = tx_data_r;
  assign bus.tx_valid_o    = tx_valid_r;
  assign config_o          = config_r;
  assign config_active_o   = active_r;
  assign int_config_req_o  = req_r;
  assign int_config_fail_o = fail_r;
  assign int_config_done_o = done_r;

endmodule

// File: doc/uart_config_sequencer.md
# uart_config_sequencer

Runtime line-configuration controller for the UART. It sits between the RX FIFO output and the TX FIFO input. It watches the received byte stream for a run of SYN characters, then accepts configuration packets (data width, parity mode, stop bits) and answers each one with ACK or NAK. On a valid end-of-configuration packet it commits the new frame format to the TX/RX datapaths. It drives the CONFIG_REQ, CONFIG_FAIL and configuration-done interrupt sources.

## Interface
- SYN_CHAR, 8'h16, synchronisation character.
- ACK_CHAR, 8'h06, positive response byte.
- NAK_CHAR, 8'h15, negative response byte.
- SYN_NUMBER, 3, consecutive SYN bytes that open a configuration request (≥1).
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between packets in configuration mode (≥2).
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid.
- tx_data_o  out  8  response byte.
- tx_valid_o  out  1  response valid; held until tx_ready_i.
- tx_ready_i  in  1  TX path accepts byte when high with tx_valid_o.
- config_o  out  6  active format {data_width[1:0], parity_mode[1:0], stop_bits[1:0]}.
- config_active_o  out  1  high while a configuration session is open; the datapath treats rx bytes as control.
- int_config_req_o  out  1  one-cycle pulse, session opened.
- int_config_fail_o  out  1  one-cycle pulse, session aborted.
- int_config_done_o  out  1  one-cycle pulse, new format committed.

## Operation
- States: IDLE, CFG_WAIT, RESPOND, plus internal flags commit_pending and fail_pending.
- Reset: state IDLE, config_o = 6'b11_00_00 (8 bits, even parity, 1 stop bit), all other outputs 0, SYN counter 0, shadow = config_o.
- IDLE: each rx_valid_i with SYN_CHAR increments syn_cnt. Any other byte clears syn_cnt to 0. The byte making syn_cnt == SYN_NUMBER causes the following:
  - go to CFG_WAIT;
  - clear syn_cnt;
  - load shadow ← config_o;
  - pulse int_config_req_o;
  - set config_active_o.
- Packet format: [7:4] must be 0, [3:2] = ID, [1:0] = option.
  - ID 01 (data width): all options valid.
  - ID 10 (parity): all valid; 10 and 11 both mean disabled.
  - ID 11 (stop bits): 00 and 01 valid; 10 and 11 reserved → invalid.
  - ID 00 (end): valid only with option 00.
- CFG_WAIT, on rx_valid_i:
  - valid field packet → write shadow field, tx_data ← ACK_CHAR, go to RESPOND.
  - valid end packet → ACK_CHAR, set commit_pending, go to RESPOND.
  - invalid packet → NAK_CHAR, set fail_pending, go to RESPOND.
- Timeout: the counter clears on entry to CFG_WAIT and on each byte received there. When it reaches TIMEOUT_CYCLES-1 with no byte, the block does all of the following in that cycle:
  - pulses int_config_fail_o;
  - goes to IDLE;
  - sends no response byte;
  - leaves config_o unchanged;
  - clears config_active_o.
- RESPOND: tx_valid_o=1 and tx_data_o held stable until the tx_valid_o & tx_ready_i handshake. On that handshake cycle:
  - commit_pending → config_o ← shadow, pulse int_config_done_o, go to IDLE.
  - fail_pending → pulse int_config_fail_o, discard shadow, go to IDLE.
  - otherwise → go to CFG_WAIT.
- config_active_o clears on the same edge as the IDLE transition.
- rx_valid_i while in RESPOND: byte dropped, no state effect. The timeout counter is frozen in RESPOND.
- Commit ordering: the ACK for the end packet is emitted under the old format; the new format takes effect after that handshake.
- Reset mid-session: returns to the reset state and restores the default config_o. No pulse is issued.

## Timing
- SYN detect → int_config_req_o pulse and config_active_o high on the clock edge that samples the final SYN strobe, so they are visible 1 cycle after it.
- Packet strobe → tx_valid_o high the next cycle. Minimum session per packet is 2 cycles (tx_ready_i tied high).
- config_o changes only on the end-packet handshake edge, coincident with int_config_done_o.
- Interrupt pulses are exactly 1 cycle. At most one interrupt pulse is active per cycle.

## Test plan
- Three 0x16 strobes, then 0x05 (DW 6-bit), 0x09 (odd), 0x0D (2 stop), 0x00, with tx_ready_i=1 → four ACK bytes 0x06; config_o = 6'b01_01_01 only after the fourth handshake; one int_config_done_o pulse.
- Sequence 0x16, 0x16, 0x41, 0x16, 0x16 → no session opened (syn_cnt cleared by 0x41); int_config_req_o never asserted.
- Session open, send 0x0E (reserved stop bits) → NAK 0x15; int_config_fail_o on the handshake; config_o stays 6'b11_00_00; back in IDLE.
- Session open, no byte for TIMEOUT_CYCLES (parameter set to 16) → int_config_fail_o after 15 cycles; tx_valid_o never asserted; config_active_o low.
- tx_ready_i held low 10 cycles during RESPOND, with an extra rx byte injected → tx_data_o stable at 0x06; extra byte ignored; timeout does not fire.
- rst_n_i asserted while in RESPOND after a 0x05 packet → all outputs 0 immediately; config_o = 6'b11_00_00; no pulses.
